// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
// Sits between the circle generator and the framebuffer write port. Incoming
// pixel strobes are clipped to the visible window, stripped of back-to-back
// duplicates, and queued. The queue drains through a single output register
// toward a framebuffer that may stall. A clear sequencer can take over the
// output register and sweep the whole window in raster order. Pixels that
// arrive during a clear stay queued and are drawn after it.
module pixel_write_buffer #(
   parameter int DEPTH   = 16,
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int COLOR_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_we,
   input  logic [15:0]        pix_addr,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               clear,
   input  logic [COLOR_W-1:0] clear_color,
   input  logic               fb_ready,
   output logic               fb_we,
   output logic [15:0]        fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               full,
   output logic               empty,
   output logic               busy,
   output logic               overflow,
   output logic [7:0]         drop_cnt
);

   localparam int         AW      = $clog2(DEPTH);
   localparam int         EW      = 16 + COLOR_W;
   localparam logic [8:0] H_LIM   = 9'(H_RES);
   localparam logic [8:0] V_LIM   = 9'(V_RES);
   localparam logic [7:0] X_LAST  = 8'(H_RES - 1);
   localparam logic [7:0] Y_LAST  = 8'(V_RES - 1);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_WAIT = 2'd1,
      ST_CLEAR    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Queue storage and pointers (one extra MSB to tell full from empty)
   logic [EW-1:0]       r_mem [DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic [AW:0]         w_wr_nxt;
   logic [AW:0]         w_rd_nxt;
   logic                r_full;
   logic                r_empty;
   logic [EW-1:0]       w_head;

   // Duplicate tracking: the most recently queued entry
   logic                r_last_vld;
   logic [15:0]         r_last_addr;
   logic [COLOR_W-1:0]  r_last_color;

   logic                r_overflow;
   logic [7:0]          r_drop_cnt;

   // Output register presented to the framebuffer
   logic                r_fb_we;
   logic [15:0]         r_fb_addr;
   logic [COLOR_W-1:0]  r_fb_data;

   logic [COLOR_W-1:0]  r_clr_color;

   // Input filter
   logic [7:0]          w_x;
   logic [7:0]          w_y;
   logic                w_clip;
   logic                w_dup;
   logic                w_keep;
   logic                w_push;

   // Sequencing controls
   logic                w_out_free;
   logic                w_pop;
   logic                w_load_scan;
   logic                w_scan_first;
   logic                w_scan_last;
   logic                w_out_clr;
   logic                w_clr_accept;
   logic [15:0]         w_scan_addr;

   assign w_x    = pix_addr[7:0];
   assign w_y    = pix_addr[15:8];
   assign w_clip = ({1'b0, w_x} >= H_LIM) || ({1'b0, w_y} >= V_LIM);
   assign w_dup  = r_last_vld && (pix_addr == r_last_addr) && (pix_color == r_last_color);
   assign w_keep = pix_we && !w_clip && !w_dup;
   // Gate on the full flag as it stood at the start of the cycle; a pop in
   // the same cycle does not make room for this push.
   assign w_push = w_keep && !r_full;

   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_out_free  = !r_fb_we || fb_ready;
   assign w_scan_last = (r_fb_addr == {Y_LAST, X_LAST});

   assign w_wr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
   assign w_rd_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and output-register control
   always_comb begin
      w_state_nxt  = r_state;
      w_pop        = 1'b0;
      w_load_scan  = 1'b0;
      w_scan_first = 1'b0;
      w_out_clr    = 1'b0;
      w_clr_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (clear) begin
               // Stop popping from the acceptance cycle on so that everything
               // still queued lands after the clear; only let the current
               // write finish.
               w_clr_accept = 1'b1;
               w_state_nxt  = ST_CLR_WAIT;
               w_out_clr    = w_out_free;
            end else if (w_out_free) begin
               if (!r_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_out_clr = 1'b1;
               end
            end
         end
         ST_CLR_WAIT: begin
            if (w_out_free) begin
               w_state_nxt  = ST_CLEAR;
               w_load_scan  = 1'b1;
               w_scan_first = 1'b1;
            end
         end
         ST_CLEAR: begin
            // The output register always holds a scan write here
            if (fb_ready) begin
               if (w_scan_last) begin
                  w_state_nxt = ST_IDLE;
                  if (!r_empty) begin
                     w_pop = 1'b1;
                  end else begin
                     w_out_clr = 1'b1;
                  end
               end else begin
                  w_load_scan = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Raster scan address: the output register doubles as the scan position
   always_comb begin
      w_scan_addr = 16'h0000;
      if (!w_scan_first) begin
         if (r_fb_addr[7:0] == X_LAST) begin
            w_scan_addr = {r_fb_addr[15:8] + 8'd1, 8'd0};
         end else begin
            w_scan_addr = {r_fb_addr[15:8], r_fb_addr[7:0] + 8'd1};
         end
      end
   end

   // Output register: loaded from the queue head or the scan, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fb_we   <= 1'b0;
         r_fb_addr <= 16'h0000;
         r_fb_data <= '0;
      end else if (w_pop) begin
         r_fb_we   <= 1'b1;
         r_fb_addr <= w_head[EW-1:COLOR_W];
         r_fb_data <= w_head[COLOR_W-1:0];
      end else if (w_load_scan) begin
         r_fb_we   <= 1'b1;
         r_fb_addr <= w_scan_addr;
         r_fb_data <= r_clr_color;
      end else if (w_out_clr) begin
         r_fb_we   <= 1'b0;
      end
   end

   // Fill colour captured when a clear is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_color <= '0;
      end else if (w_clr_accept) begin
         r_clr_color <= clear_color;
      end
   end

   // Queue storage write port
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {pix_addr, pix_color};
      end
   end

   // Queue pointers and registered full/empty flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                     (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
         r_empty  <= (w_wr_nxt == w_rd_nxt);
      end
   end

   // Last-push-valid flag; a clear forgets the previous entry so the same
   // pixel can be redrawn on top of the fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_vld <= 1'b0;
      end else if (w_clr_accept) begin
         r_last_vld <= 1'b0;
      end else if (w_push) begin
         r_last_vld <= 1'b1;
      end
   end

   // Last pushed address/colour, qualified by r_last_vld
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_last_addr  <= pix_addr;
         r_last_color <= pix_color;
      end
   end

   // Drop statistics: saturating filter count and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= 8'd0;
         r_overflow <= 1'b0;
      end else begin
         if (pix_we && (w_clip || w_dup) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_keep && r_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign fb_we    = r_fb_we;
   assign fb_addr  = r_fb_addr;
   assign fb_data  = r_fb_data;
   assign full     = r_full;
   assign empty    = r_empty;
   assign busy     = (r_state != ST_IDLE) || !r_empty || r_fb_we;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/pixel_write_buffer.md
# pixel_write_buffer

Downstream stage of the Bresenham circle generator: accepts its per-cycle `{y,x}` pixel write strobes, clips them to the visible window, suppresses back-to-back duplicates, and queues them in a FIFO. Drains the FIFO to a framebuffer write port that may stall. Also provides a full-screen clear sequencer. Sits between the circle generator and the framebuffer RAM/arbiter, decoupling the generator's one-pixel-per-clock burst from memory backpressure.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `H_RES`, 160: visible width; x ≥ `H_RES` is clipped.
- `V_RES`, 120: visible height; y ≥ `V_RES` is clipped.
- `COLOR_W`, 3: pixel colour width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pix_we`  in  1  pixel strobe from the circle generator.
- `pix_addr`  in  16  `{y[7:0], x[7:0]}`.
- `pix_color`  in  `COLOR_W`  colour for this pixel.
- `clear`  in  1  single-cycle request to fill the window with `clear_color`.
- `clear_color`  in  `COLOR_W`  fill colour, sampled when the clear is accepted.
- `fb_ready`  in  1  framebuffer accepts the current write this cycle.
- `fb_we`  out  1  write valid.
- `fb_addr`  out  16  `{y, x}` of the write.
- `fb_data`  out  `COLOR_W`  write colour.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  high in `CLEAR`/`CLR_WAIT`, or while the FIFO or output register holds data.
- `overflow`  out  1  sticky; a filtered pixel was lost to `full`.
- `drop_cnt`  out  8  saturating count of clipped plus duplicate pixels.

## Operation
- **Input filter**, evaluated in the cycle `pix_we` = 1:
  - Clip if x ≥ `H_RES` or y ≥ `V_RES`.
  - Duplicate if address and colour equal the last pushed entry and the last-push-valid flag is set.
  - Clipped or duplicate: not pushed; `drop_cnt` +1, saturating at 255.
  - Otherwise push if not `full`. If `full`, drop and set `overflow`. Pushes gate on `full` sampled at the start of the cycle, even when a pop occurs in the same cycle.
- **Last-push-valid flag**: cleared by reset and on clear acceptance.
- **Output register**: holds `fb_addr`/`fb_data`/`fb_we`.
  - Loaded from the FIFO head when empty, or in the same cycle its current write is accepted (`fb_we && fb_ready`).
  - While `fb_we` = 1 and `fb_ready` = 0, `fb_addr`/`fb_data` hold stable.
- **FIFO pointers**: `log2(DEPTH)+1` bits, wrap naturally. `full` when the MSBs differ and the rest are equal; `empty` when the pointers are equal.
- **State machine**:
  - `IDLE`: normal draining. On `clear`, go to `CLR_WAIT` and latch `clear_color`.
  - `CLR_WAIT`: no new FIFO pops. Wait until the output register is empty or its write is accepted, then go to `CLEAR` with the scan at (0,0).
  - `CLEAR`: output register driven by the scan counter, raster order x fastest. Advance on `fb_ready`. After (`H_RES`-1, `V_RES`-1) is accepted, return to `IDLE`.
- **During `CLR_WAIT`/`CLEAR`**:
  - The input filter and FIFO pushes continue. Queued pixels are drawn after the clear completes.
  - `clear` is ignored.
- **Reset mid-operation**: FIFO is emptied, any scan is abandoned, the state goes to `IDLE`, and all outputs take their reset values.

## Timing
- **Reset values**: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `full`=0, `empty`=1, `busy`=0, `overflow`=0, `drop_cnt`=0; state `IDLE`.
- **Latency**: pixel sampled at edge k with FIFO and output register empty → `fb_we`=1 after edge k+1.
- **Throughput**: with `fb_ready` held high, one write per cycle sustained, matching the generator's rate.
- `fb_we` changes only at clock edges. It never drops while `fb_ready` = 0 with a write pending.
- **Clear duration**: first clear write at edge c+1 after acceptance if the output register is idle. Total `H_RES`·`V_RES` accepted writes.
- **Flags**: `full`/`empty` are registered and reflect the state after the edge. `overflow` clears only on reset.

## Test plan
- **Streaming**: `fb_ready`=1; push (x=10,y=20,c=5), then (11,20,5) → `fb_we` with `fb_addr`=0x140A after edge 2, then 0x140B the next cycle; `empty`=1 afterwards.
- **Clip/duplicate**: push (200,5), (5,130), then (7,7) twice → exactly one write, 0x0707; `drop_cnt`=3.
- **Backpressure/full**: `fb_ready`=0; 18 distinct pixels with `DEPTH`=16 → one held in the output register plus 16 in the FIFO; the 18th is dropped; `full`=1, `overflow`=1. Release `fb_ready` → 17 writes in push order, stable addresses while stalled.
- **Clear**: `clear` with `clear_color`=2, `H_RES`=4, `V_RES`=2 → writes 0x0000..0x0003, 0x0100..0x0103 with data 2. A pixel (1,1) pushed mid-clear is written after 0x0103.
- **Clear vs pending**: `fb_ready`=0 with a pixel in the output register; assert `clear` → that pixel is written first once `fb_ready`=1, then the scan starts at 0x0000.
- **Reset mid-clear**: drop `rst_n` asynchronously → `fb_we`=0 immediately, `empty`=1, `busy`=0, `drop_cnt`=0.
